// File: rtl/decoder3to8_seq_pkg.sv
// Shared types and helpers for the registered 3-to-8 active-low line decoder.
package decoder3to8_seq_pkg;

  localparam int LINES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // One-cold active-low decode: only bit idx is driven low.
  function automatic logic [LINES-1:0] onecold(input logic [2:0] idx);
    return ~(LINES'(1) << idx);
  endfunction

endpackage

// File: rtl/sync_fifo_simple.sv
// Small synchronous FIFO with a separate occupancy counter; no push bypass when full.
module sync_fifo_simple #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic [W-1:0]                   i_data,
  input  logic                           i_pop,
  output logic [W-1:0]                   o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rptr];

  // Full is judged on the registered level, so a same-cycle pop never frees a slot for a push.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/decoder3to8_seq.sv
// Registered 3-to-8 decoder: queues inverted codes and replays each as a timed active-low strobe.
module decoder3to8_seq
  import decoder3to8_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3,
  parameter int GAP   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2:0]                     in_a,
  output logic [LINES-1:0]               y_n,
  output logic                           busy,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_e          r_state;
  logic [2:0]      r_line;
  logic [CW-1:0]   r_cnt;
  logic [LINES-1:0] r_y_n;
  logic            r_busy;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic [2:0]      w_line;

  sync_fifo_simple #(
    .W     (3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (in_valid),
    .i_data  (~in_a),
    .i_pop   (w_pop),
    .o_data  (w_line),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign in_ready = !w_full;
  assign w_pop    = (r_state == ST_IDLE) && !en_n && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_line  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_line  <= w_line;
            r_cnt   <= HOLD_LD;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == '0) begin
            if (GAP > 0) begin
              r_cnt   <= GAP_LD;
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs trail the FSM by one register stage so the strobe is glitch-free and input-isolated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_n  <= '1;
      r_busy <= 1'b0;
    end else begin
      r_y_n  <= (r_state == ST_DRIVE) ? onecold(r_line) : '1;
      r_busy <= (r_state != ST_IDLE);
    end
  end

  assign y_n  = r_y_n;
  assign busy = r_busy;

endmodule

// File: tb/tb_decoder3to8_seq.sv
// Self-checking bench: two decoder instances against a timeline-based reference model.
module tb_decoder3to8_seq;

  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_a = 3'd0;

  logic       rdy0, rdy1, busy0, busy1;
  logic [7:0] y0, y1;
  logic [2:0] lvl0, lvl1;
  logic [25:0] act;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;

  // Model: each instance is a queue plus the edge at which its last pulse was launched.
  int mH [2] = '{3, 1};
  int mG [2] = '{1, 0};
  int mf [2][DEP];
  int mhead [2];
  int mcnt  [2];
  int mlpe  [2];
  int mnext [2];
  int mline [2];

  always #5 clk = ~clk;

  decoder3to8_seq #(.DEPTH(DEP), .HOLD(3), .GAP(1)) u_dut0 (
    .clk(clk), .rst(rst), .en_n(en_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .y_n(y0), .busy(busy0), .level(lvl0)
  );

  decoder3to8_seq #(.DEPTH(DEP), .HOLD(1), .GAP(0)) u_dut1 (
    .clk(clk), .rst(rst), .en_n(en_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .y_n(y1), .busy(busy1), .level(lvl1)
  );

  assign act = {y0, busy0, lvl0, rdy0, y1, busy1, lvl1, rdy1};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; mcnt[k] = 0; mlpe[k] = -1000; mnext[k] = 0; mline[k] = 0;
    end
  endfunction

  // Called at each rising edge with the inputs that edge samples.
  function automatic void model_edge();
    bit push_ok;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      push_ok = in_valid && (mcnt[k] < DEP);
      if (!en_n && mcnt[k] > 0 && cyc >= mnext[k]) begin
        mline[k] = mf[k][mhead[k]];
        mhead[k] = (mhead[k] + 1) % DEP;
        mcnt[k]--;
        mlpe[k]  = cyc;
        mnext[k] = cyc + mH[k] + mG[k] + 1;
      end
      if (push_ok) begin
        mf[k][(mhead[k] + mcnt[k]) % DEP] = 7 - int'(in_a);
        mcnt[k]++;
      end
    end
  endfunction

  function automatic logic [12:0] exp_vec(int k);
    logic [7:0] y;
    logic       b;
    y = 8'hFF;
    if (cyc >= mlpe[k] + 1 && cyc <= mlpe[k] + mH[k]) y = 8'(255 - (1 << mline[k]));
    b = (cyc >= mlpe[k] + 1) && (cyc <= mlpe[k] + mH[k] + mG[k]);
    return {y, b, 3'(mcnt[k]), (mcnt[k] < DEP)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    asserts++;
    if (act !== {exp_vec(0), exp_vec(1)}) begin
      fails++; $display("FAIL reset_async got=%h exp=%h", act, {exp_vec(0), exp_vec(1)});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    en_n = 1'b0; in_valid = 1'b1; in_a = 3'b101;
    tick();
    @(negedge clk) in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
    end
  endtask

  task automatic test_all_codes();
    int  idx = 0;
    bit  was_rdy;
    for (int n = 0; n < 200 && idx < 8; n++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 3'(7 - idx); was_rdy = rdy0;
      tick();
      if (was_rdy) idx++;
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL all_codes cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
    end
    if (idx < 8) begin
      fails++; $display("FAIL all_codes_timeout pushed=%0d need=8", idx);
    end
    @(negedge clk) in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL all_codes_drain cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
    end
  endtask

  task automatic test_full();
    @(negedge clk);
    en_n = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_a = 3'($urandom_range(0, 7));
      tick();
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL full cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
      @(negedge clk);
    end
    in_valid = 1'b0; en_n = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL full_drain cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
    end
  endtask

  task automatic test_enable_gating();
    bit seen = 1'b0;
    @(negedge clk);
    en_n = 1'b0; in_valid = 1'b1; in_a = 3'b110;
    tick();
    @(negedge clk) in_a = 3'b001;
    tick();
    @(negedge clk) in_valid = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      seen = (y0 !== 8'hFF);
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL gate_wait cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
    end
    if (!seen) begin
      fails++; $display("FAIL gate_timeout y_n=%h never left FF", y0);
    end
    tick();
    @(negedge clk) en_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 10) @(negedge clk) en_n = 1'b0;
      tick();
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL gate cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit seen = 1'b0;
    @(negedge clk);
    en_n = 1'b0; in_valid = 1'b1; in_a = 3'b000;
    tick();
    @(negedge clk) in_a = 3'b011;
    tick();
    @(negedge clk) in_valid = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      seen = (y0 === 8'h7F);
    end
    if (!seen) begin
      fails++; $display("FAIL rstmid_timeout y_n=%h never 7F", y0);
    end
    #2 rst = 1'b1;
    #1 model_reset();
    asserts++;
    if (act !== {exp_vec(0), exp_vec(1)}) begin
      fails++; $display("FAIL rstmid_async got=%h exp=%h", act, {exp_vec(0), exp_vec(1)});
    end
    tick();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL rstmid_after cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
    end
  endtask

  task automatic test_gap0();
    @(negedge clk);
    en_n = 1'b0; in_valid = 1'b1; in_a = 3'b010;
    tick();
    @(negedge clk) in_a = 3'b100;
    tick();
    @(negedge clk) in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL gap0 cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      in_a     = 3'($urandom_range(0, 7));
      en_n     = ($urandom_range(0, 5) == 0);
      tick();
      asserts++;
      if (act !== {exp_vec(0), exp_vec(1)}) begin
        fails++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act, {exp_vec(0), exp_vec(1)});
      end
    end
    @(negedge clk) in_valid = 1'b0; en_n = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_codes();
    test_full();
    test_enable_gating();
    test_reset_mid_pulse();
    test_gap0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
